// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter.
// Operand width, default widths and the rotate-priority pick.
package adder_arb_pkg;

  localparam int OP_W      = 8;
  localparam int DEF_ID_W  = 2;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_REQ   = 8;

  // First set bit of valid searching upward from ptr, modulo n.
  function automatic int next_grant(
    input logic [MAX_REQ-1:0] valid,
    input int                 ptr,
    input int                 n
  );
    int   g;
    int   idx;
    logic hit;
    g   = 0;
    idx = 0;
    hit = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) % n;
      if (!hit && k < n && valid[idx]) begin
        g   = idx;
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/adder7.sv
// 8-bit Kogge-Stone prefix adder, sum mod 256.
// The carry-out is intentionally dropped.
module adder7
  import adder_arb_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] sum
);

  logic [OP_W-1:0] gl [4];
  logic [OP_W-1:0] pl [4];

  // Three prefix levels (span 1, 2, 4) build every bit's carry.
  always_comb begin
    gl[0] = a & b;
    pl[0] = a ^ b;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < OP_W; i++) begin
        if (i >= (1 << l)) begin
          gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i-(1<<l)]);
          pl[l+1][i] = pl[l][i] & pl[l][i-(1<<l)];
        end else begin
          gl[l+1][i] = gl[l][i];
          pl[l+1][i] = pl[l][i];
        end
      end
    end
    sum = pl[0] ^ {gl[3][OP_W-2:0], 1'b0};
  end

endmodule

// File: rtl/adder_rr_pick.sv
// Combinational round-robin priority encoder.
// Picks the first valid requester at or after rr_ptr.
module adder_rr_pick
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    grant,
  output logic               grant_any
);

  logic [MAX_REQ-1:0] valid8;
  int                 ptr_i;
  int                 g_i;

  // Widen to the fixed-size search and pick the winner.
  always_comb begin
    valid8              = '0;
    valid8[NUM_REQ-1:0] = req_valid;
    ptr_i               = 0;
    ptr_i[ID_W-1:0]     = rr_ptr;
    g_i                 = next_grant(valid8, ptr_i, NUM_REQ);
    grant               = g_i[ID_W-1:0];
    grant_any           = |req_valid;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one 8-bit adder among NUM_REQ requesters.
// Round-robin grant, one registered result per cycle.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = DEF_ID_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OP_W-1:0]        rsp_sum,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       txn_count,
  output logic                   busy
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            grant_any;
  logic            can_accept;
  logic            accept;
  logic [OP_W-1:0] a_g;
  logic [OP_W-1:0] b_g;
  logic [OP_W-1:0] sum_g;
  logic [ID_W-1:0] ptr_nxt;

  adder_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_any (grant_any)
  );

  adder7 u_add (
    .a   (a_g),
    .b   (b_g),
    .sum (sum_g)
  );

  // Grant handshake, operand mux and pointer advance.
  always_comb begin
    can_accept = !rsp_valid || rsp_ready;
    accept     = grant_any && can_accept && !wb_rst_i;
    req_ready  = '0;
    a_g        = '0;
    b_g        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        req_ready[i] = accept;
        a_g          = req_a[OP_W*i +: OP_W];
        b_g          = req_b[OP_W*i +: OP_W];
      end
    end
    if (grant == ID_W'(NUM_REQ - 1)) ptr_nxt = '0;
    else                              ptr_nxt = grant + 1'b1;
    busy = rsp_valid || (|req_valid);
  end

  // Single-entry result register and round-robin pointer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum_g;
      rsp_id    <= grant;
      rr_ptr    <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Count completed responses; wraps naturally.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                    txn_count <= '0;
    else if (rsp_valid && rsp_ready) txn_count <= txn_count + 1'b1;
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter.
// Hand-computed vectors for sum, id, handshake and reset.
module tb_adder_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic [15:0] txn_count;
  logic        busy;

  int checks;
  int failures;

  adder_rr_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .txn_count (txn_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a,
                        input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  logic [1:0] exp_id  [6];
  logic [7:0] exp_sum [4];
  logic [7:0] held_sum;

  initial begin
    checks    = 0;
    failures  = 0;
    exp_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_sum   = '{8'h01, 8'h12, 8'h23, 8'h34};
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_cnt", 32'(txn_count), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_sum", 32'(rsp_sum), 0);

    rst = 1'b0;
    set_op(0, 8'h12, 8'h34);
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("t1_valid", 32'(rsp_valid), 1);
    chk("t1_sum", 32'(rsp_sum), 32'h46);
    chk("t1_id", 32'(rsp_id), 0);
    chk("t1_cnt0", 32'(txn_count), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_cnt1", 32'(txn_count), 1);
    chk("t1_drain", 32'(rsp_valid), 0);
    chk("t1_idle", 32'(busy), 0);

    req_valid = 4'b0100;
    set_op(2, 8'hFF, 8'h01);
    #1;
    chk("t2_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("t2_wrap", 32'(rsp_sum), 32'h00);
    chk("t2_id", 32'(rsp_id), 2);
    set_op(2, 8'h80, 8'h80);
    #1;
    chk("t2_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("t2_wrap2", 32'(rsp_sum), 32'h00);
    chk("t2_valid2", 32'(rsp_valid), 1);
    chk("t2_cnt", 32'(txn_count), 2);
    tick();
    chk("t2_cnt3", 32'(txn_count), 3);

    req_valid = 4'b0010;
    set_op(1, 8'h05, 8'h06);
    #1;
    chk("t5_ready1", 32'(req_ready), 32'b0010);
    tick();
    chk("t5_id1", 32'(rsp_id), 1);
    chk("t5_sum1", 32'(rsp_sum), 32'h0B);
    req_valid = 4'b0110;
    set_op(2, 8'h10, 8'h20);
    #1;
    chk("t5_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    #1;
    chk("t5_id2", 32'(rsp_id), 2);
    chk("t5_sum2", 32'(rsp_sum), 32'h30);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 8'h10 * i + 8'h01, 8'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t3_valid%0d", k), 32'(rsp_valid), 1);
      chk($sformatf("t3_id%0d", k), 32'(rsp_id), 32'(exp_id[k]));
      chk($sformatf("t3_sum%0d", k), 32'(rsp_sum),
          32'(exp_sum[exp_id[k]]));
    end
    chk("t3_cnt", 32'(txn_count), 5);

    rsp_ready = 1'b0;
    held_sum  = rsp_sum;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_ready%0d", k), 32'(req_ready), 0);
      tick();
      chk($sformatf("t4_id%0d", k), 32'(rsp_id), 1);
      chk($sformatf("t4_sum%0d", k), 32'(rsp_sum), 32'(held_sum));
      chk($sformatf("t4_valid%0d", k), 32'(rsp_valid), 1);
    end
    chk("t4_cnt_hold", 32'(txn_count), 5);
    rsp_ready = 1'b1;
    #1;
    chk("t4_release", 32'(req_ready), 32'b0100);
    tick();
    chk("t4_id_rel", 32'(rsp_id), 2);
    chk("t4_sum_rel", 32'(rsp_sum), 32'h23);
    chk("t4_cnt_rel", 32'(txn_count), 6);

    req_valid = '0;
    rsp_ready = 1'b0;
    #2;
    chk("t6_pre", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_async", 32'(rsp_valid), 0);
    chk("t6_cnt", 32'(txn_count), 0);
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6_stale%0d", k), 32'(rsp_valid), 0);
    end
    chk("t6_cnt_end", 32'(txn_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one 8-bit prefix adder (`adder7`, combinational, sum mod 256, no carry-out) between NUM_REQ requesters. Each requester has a valid/ready operand port. A round-robin arbiter grants one requester per cycle and registers the sum, tagged with the requester ID. The result goes out on a single valid/ready response port. The block sits between the user-project logic blocks and the shared adder datapath.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
ID_W, 2, width of the requester ID tag; must satisfy 2**ID_W >= NUM_REQ
CNT_W, 16, width of the completed-transaction counter

Ports:
wb_clk_i  in  1  clock, rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  8*NUM_REQ  operand A; requester i occupies bits [8i+7:8i]
req_b  in  8*NUM_REQ  operand B; same packing as req_a
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts the result
rsp_sum  out  8  (a+b) mod 256 for the granted request
rsp_id  out  ID_W  index of the requester that produced rsp_sum
txn_count  out  CNT_W  completed responses (rsp_valid & rsp_ready), wraps to 0
busy  out  1  high when rsp_valid is high or any req_valid is high

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, txn_count=0, rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Output stage is a single-entry register. can_accept = !rsp_valid | rsp_ready.
- Arbitration is combinational each cycle:
  - Search req_valid starting at index rr_ptr and ascending modulo NUM_REQ. The first set bit is the winner g.
  - req_ready[g] = can_accept. All other req_ready bits are 0.
  - If no req_valid bit is set, req_ready = 0.
- Accept = req_valid[g] & req_ready[g]. On the accepting edge:
  - rsp_sum <= adder7(a_g, b_g)
  - rsp_id <= g
  - rsp_valid <= 1
  - rr_ptr <= (g+1) mod NUM_REQ
- Latency and throughput:
  - The result appears exactly one cycle after acceptance.
  - Throughput is one result per cycle when rsp_ready is held high.
- Simultaneous drain and fill: if rsp_valid & rsp_ready and a new accept occur on the same edge, the register loads the new result and rsp_valid stays 1. No bubble, no loss.
- Drain with no new accept: rsp_valid <= 0. rsp_sum and rsp_id hold their last values; they are don't-care while rsp_valid=0.
- Stall (rsp_valid=1, rsp_ready=0):
  - req_ready=0 on all ports.
  - rsp_sum and rsp_id are held stable.
  - rr_ptr is unchanged.
- Requester-side contract: requesters hold req_valid and operands stable until accepted. The arbiter does not rely on this for correctness; it samples the operands only on the accepting edge.
- rr_ptr advances only on an accept, never while idle. Fairness: a continuously asserted requester is granted within NUM_REQ accepts.
- Arithmetic: the sum is 8-bit, mod 256, and the carry is discarded, e.g. 0xFF+0x01 = 0x00.
- txn_count increments on each rsp_valid & rsp_ready edge and wraps from 2**CNT_W-1 to 0.
- Reset mid-transaction: any pending result is discarded, rsp_valid drops immediately (asynchronous), and no response is produced after reset release.
- Requester indices >= NUM_REQ never exist; the bits of rsp_id above the used range are always 0.

Decomposition:
- Shared package/include `adder_arb_pkg` holds:
  - localparam OP_W=8
  - a function for the rotate-priority pick (next_grant)
  - the default ID_W/CNT_W values
- One sub-module, `adder_rr_pick`: combinational round-robin priority encoder. Inputs are req_valid and rr_ptr; outputs are the grant index and grant_any.
- The `adder7` instance lives in the top level and is fed by the operand mux.

Test Plan:
1. Reset, then requester 0 sends a=0x12, b=0x34 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x46, rsp_id=0; txn_count=1 after the following edge.
2. Wrap: requester 2 sends a=0xFF, b=0x01 -> rsp_sum=0x00, rsp_id=2. Separately, requester 2 sends a=0x80, b=0x80 -> rsp_sum=0x00.
3. All four requesters valid continuously with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one per cycle, with no gaps.
4. Backpressure: rsp_ready=0 for 5 cycles while rsp_valid=1 -> req_ready=0 on all ports, and rsp_sum/rsp_id stay constant. On release, the next requester in round-robin order is granted on the same edge the held result drains.
5. Sparse traffic: rr_ptr=3, only req 1 valid -> req 1 granted; the next grant with req 1 and req 2 both valid goes to req 2.
6. Assert wb_rst_i asynchronously while rsp_valid=1 -> rsp_valid drops with no clock edge and txn_count=0; after release, no stale response appears.
